// File: rtl/sp_ram_banked_wrap_if.sv
// Request/response bus of the banked single-port RAM wrapper.
// The master drives requests; the slave returns grant, responses and init status.
interface sp_ram_banked_wrap_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic                  req_i;
    logic                  gnt_o;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic [BE_W-1:0]       be_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  bypass_en_i;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;
    logic                  init_done_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, bypass_en_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, init_done_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, bypass_en_i,
        output gnt_o, rvalid_o, rdata_o, err_o, init_done_o
    );
endinterface

// File: rtl/sp_ram_banked_wrap.sv
// Word-interleaved multi-bank single-port RAM with req/gnt/rvalid handshake,
// byte enables, optional output register and post-reset zero initialisation.
module sp_ram_banked_wrap #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_WORDS = 1024,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic                 clk,
    input  logic                 rst_i,
    sp_ram_banked_wrap_if.slave  bus
);
    localparam int unsigned BE_W       = DATA_WIDTH / 8;
    localparam int unsigned RAM_SIZE   = NUM_BANKS * BANK_WORDS * DATA_WIDTH / 8;
    localparam int unsigned ADDR_WIDTH = $clog2(RAM_SIZE);
    localparam int unsigned OFS        = $clog2(BE_W);
    localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
    localparam int unsigned BSEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int unsigned ROW_W      = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int unsigned IDX_W      = ADDR_WIDTH - OFS;

    typedef enum logic {ST_INIT, ST_DONE} state_e;

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  init_we;
    logic                  init_done_q;

    logic [IDX_W-1:0]      word_idx;
    logic [BSEL_W-1:0]     bank_sel;
    logic [ROW_W-1:0]      row;
    logic                  misaligned;
    logic                  gnt;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  v1_q, err1_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    // Address decode: low word-index bits pick the bank, the rest pick the row
    assign word_idx = bus.addr_i[ADDR_WIDTH-1:OFS];
    assign row      = ROW_W'(word_idx >> BANK_BITS);

    if (BANK_BITS > 0) begin : g_bank_sel
        assign bank_sel = word_idx[BSEL_W-1:0];
    end else begin : g_single_bank
        assign bank_sel = '0;
    end

    if (OFS > 0) begin : g_misalign
        assign misaligned = |bus.addr_i[OFS-1:0];
    end else begin : g_no_misalign
        assign misaligned = 1'b0;
    end

    assign gnt         = bus.req_i & init_done_q;
    assign bus.gnt_o   = gnt;
    assign bus.init_done_o = init_done_q;
    assign wr_en       = gnt & bus.we_i & ~misaligned & ~bus.bypass_en_i & ~rst_i;

    // Init FSM state register
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= (INIT_ZERO != 0) ? ST_INIT : ST_DONE;
            row_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            init_done_q <= (state_d == ST_DONE);
        end
    end

    // Init FSM: sweep every row once, clearing it in all banks
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (row_q == ROW_W'(BANK_WORDS - 1)) begin
                    state_d = ST_DONE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // Behavioural bank arrays; each can be replaced by a hard macro
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
        logic                  bank_we;

        assign bank_we = wr_en && (bank_sel == BSEL_W'(b));

        always_ff @(posedge clk) begin
            if (init_we) begin
                mem[row_q] <= '0;
            end else if (bank_we) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (bus.be_i[k]) mem[row][k*8 +: 8] <= bus.wdata_i[k*8 +: 8];
                end
            end
        end

        assign bank_rdata[b] = mem[row];
    end

    assign rd_word = bank_rdata[bank_sel];

    // First response stage; data only reloads on a grant so it holds otherwise
    always_ff @(posedge clk) begin
        if (rst_i) begin
            v1_q     <= 1'b0;
            err1_q   <= 1'b0;
            rdata1_q <= '0;
        end else begin
            v1_q <= gnt;
            if (gnt) begin
                err1_q   <= misaligned;
                rdata1_q <= (!bus.we_i && !misaligned) ? rd_word : '0;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  v2_q, err2_q;
        logic [DATA_WIDTH-1:0] rdata2_q;

        always_ff @(posedge clk) begin
            if (rst_i) begin
                v2_q     <= 1'b0;
                err2_q   <= 1'b0;
                rdata2_q <= '0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    err2_q   <= err1_q;
                    rdata2_q <= rdata1_q;
                end
            end
        end

        assign bus.rvalid_o = v2_q;
        assign bus.err_o    = err2_q;
        assign bus.rdata_o  = rdata2_q;
    end else begin : g_no_out_reg
        assign bus.rvalid_o = v1_q;
        assign bus.err_o    = err1_q;
        assign bus.rdata_o  = rdata1_q;
    end

endmodule
